// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - instruction register, field decode and Moore FSM for the 16-bit datapath
module datapath_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [3:0]  vsel,
    output logic        write,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];

    assign shift  = ir[4:3];
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_alu;
    logic is_cmp;
    logic is_mvn;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    // IR only changes while idle, so the instruction stays stable for its whole execution.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir <= 16'h0000;
        end else if (load && (state == S_WAIT)) begin
            ir <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        w          = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        vsel       = 4'b0000;
        write      = 1'b0;
        readnum    = 3'b000;
        writenum   = 3'b000;
        ALUop      = 2'b00;

        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm) begin
                    state_next = S_WRITE_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    state_next = S_GET_B;
                end else if (is_alu) begin
                    state_next = S_GET_A;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WRITE_IMM: begin
                vsel       = 4'b0010;
                writenum   = rn;
                write      = 1'b1;
                state_next = S_WAIT;
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                state_next = S_GET_B;
            end
            S_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                // MOV reg and MVN pass B through the ALU with a zero A operand.
                ALUop = is_alu ? op : 2'b00;
                asel  = is_mov_reg || is_mvn;
                if (is_cmp) begin
                    loads      = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    loadc      = 1'b1;
                    state_next = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                vsel       = 4'b1000;
                writenum   = rd;
                write      = 1'b1;
                state_next = S_WAIT;
            end
            default: begin
                state_next = S_WAIT;
            end
        endcase
    end

endmodule
